// File: rtl/quant_pipe.sv
// quant_pipe: JPEG coefficient quantizer. Multiplies each channel's DCT
// coefficient by a reciprocal from a loadable luminance/chrominance table,
// rounds half toward +inf, saturates to OUT_W bits and streams the result out.
// Pipeline ranks: capture -> product -> round/saturate -> output register.
// All ranks advance together when the output is free or being taken.
module quant_pipe #(
  parameter int NCH     = 3,
  parameter int IN_W    = 14,
  parameter int RECIP_W = 13,
  parameter int SHIFT   = 17,
  parameter int OUT_W   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tbl_we,
  input  logic                   tbl_sel,
  input  logic [5:0]             tbl_addr,
  input  logic [RECIP_W-1:0]     tbl_data,
  output logic                   tbl_ok,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sob,
  input  logic [NCH*IN_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*OUT_W-1:0]   out_data,
  output logic [NCH-1:0]         out_sat,
  output logic                   out_eob
);

  localparam int P_W = IN_W + RECIP_W + 1;
  localparam logic signed [P_W-1:0] Q_MAX = P_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [P_W-1:0] Q_MIN = ~Q_MAX;

  logic [RECIP_W-1:0] lum_tbl [64];
  logic [RECIP_W-1:0] chr_tbl [64];
  logic               lum_ok, chr_ok;

  logic               en, accept;
  logic [5:0]         pos, beat_pos;

  logic               s1_valid, s2_valid, s3_valid;
  logic [NCH*IN_W-1:0] s1_coef;
  logic [5:0]         s1_pos, s2_pos, s3_pos;
  logic [RECIP_W-1:0] s1_lum, s1_chr;

  logic signed [P_W-1:0] prod    [NCH];
  logic signed [P_W-1:0] s2_prod [NCH];
  logic [NCH*OUT_W-1:0]  sat_q, s3_q;
  logic [NCH-1:0]        sat_flag, s3_sat;

  assign tbl_ok   = lum_ok && chr_ok;
  assign en       = !out_valid || out_ready;
  assign in_ready = tbl_ok && en;
  assign accept   = in_valid && in_ready;
  assign beat_pos = in_sob ? 6'd0 : pos;

  // Reciprocal tables: no reset, contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      if (tbl_sel) chr_tbl[tbl_addr] <= tbl_data;
      else         lum_tbl[tbl_addr] <= tbl_data;
    end
  end

  // Load flags: a table counts as loaded once its last entry is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      lum_ok <= 1'b0;
      chr_ok <= 1'b0;
    end else if (tbl_we && tbl_addr == 6'd63) begin
      if (tbl_sel) chr_ok <= 1'b1;
      else         lum_ok <= 1'b1;
    end
  end

  // Block position counter; in_sob forces the accepted beat to position 0.
  always_ff @(posedge clk) begin
    if (reset)       pos <= 6'd0;
    else if (accept) pos <= beat_pos + 6'd1;
  end

  // Stage 1: capture coefficients, position and both table entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_coef  <= in_data;
      s1_pos   <= beat_pos;
      s1_lum   <= lum_tbl[beat_pos];
      s1_chr   <= chr_tbl[beat_pos];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [IN_W-1:0]  coef;
    logic [RECIP_W-1:0]      recip;
    logic signed [P_W-1:0]   shr, q;
    logic [OUT_W-1:0]        qv;
    logic                    flag;

    assign coef    = s1_coef[c*IN_W +: IN_W];
    assign recip   = (c == 0) ? s1_lum : s1_chr;
    assign prod[c] = P_W'(coef) * $signed(P_W'({1'b0, recip}));

    assign shr = s2_prod[c] >>> SHIFT;
    assign q   = shr + $signed({{(P_W-1){1'b0}}, s2_prod[c][SHIFT-1]});

    // Clamp the rounded value into the signed OUT_W range.
    always_comb begin
      qv   = q[OUT_W-1:0];
      flag = 1'b0;
      if (q > Q_MAX) begin
        qv   = Q_MAX[OUT_W-1:0];
        flag = 1'b1;
      end else if (q < Q_MIN) begin
        qv   = Q_MIN[OUT_W-1:0];
        flag = 1'b1;
      end
    end

    assign sat_q[c*OUT_W +: OUT_W] = qv;
    assign sat_flag[c]             = flag;
  end

  // Stage 2: register the full-precision products.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= prod;
      s2_pos   <= s1_pos;
    end
  end

  // Stage 3: register the rounded, saturated values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_q     <= sat_q;
      s3_sat   <= sat_flag;
      s3_pos   <= s2_pos;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      out_eob   <= 1'b0;
    end else if (en) begin
      out_valid <= s3_valid;
      out_data  <= s3_q;
      out_sat   <= s3_sat;
      out_eob   <= (s3_pos == 6'd63);
    end
  end

endmodule

// File: tb/tb_quant_pipe.sv
// Testbench for quant_pipe: directed and random stimulus against a
// behavioural quantizer model with an in-order expected-output queue.
module tb_quant_pipe;
  localparam int NCH = 3, IN_W = 14, RECIP_W = 13, SHIFT = 17, OUT_W = 10;

  logic                 clk = 1'b0;
  logic                 reset, tbl_we, tbl_sel, tbl_ok;
  logic [5:0]           tbl_addr;
  logic [RECIP_W-1:0]   tbl_data;
  logic                 in_valid, in_ready, in_sob;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 out_valid, out_ready, out_eob;
  logic [NCH*OUT_W-1:0] out_data;
  logic [NCH-1:0]       out_sat;

  always #5 clk = ~clk;

  quant_pipe dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_sel(tbl_sel),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_ok(tbl_ok),
    .in_valid(in_valid), .in_ready(in_ready), .in_sob(in_sob), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_eob(out_eob)
  );

  typedef struct {
    logic [NCH*OUT_W-1:0] data;
    logic [NCH-1:0]       sat;
    logic                 eob;
  } beat_t;

  beat_t sb[$];
  int    ages[$];     // enabled edges seen since acceptance; visible at 3
  int    m_lum[64], m_chr[64];
  int    mpos;
  bit    m_lum_ok, m_chr_ok;
  int    checks = 0, failures = 0;
  int    out_cnt;
  int    eob_idx[$];

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void check_field(string tag, int ch, int exp);
    logic [OUT_W-1:0] e, o;
    e = exp[OUT_W-1:0];
    o = out_data[ch*OUT_W +: OUT_W];
    check(tag, o, e);
  endfunction

  function automatic longint floor_div(longint a, longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // round(coef*recip / 2^SHIFT) with ties toward +inf, then clamp
  function automatic void quantize(input int coef, input int recip, output int q, output bit s);
    longint r, hi, lo;
    r  = floor_div(longint'(coef) * recip + (longint'(1) << (SHIFT - 1)), longint'(1) << SHIFT);
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    s  = 1'b0;
    if (r > hi) begin r = hi; s = 1'b1; end
    else if (r < lo) begin r = lo; s = 1'b1; end
    q = int'(r);
  endfunction

  function automatic logic [NCH*IN_W-1:0] rand_data();
    logic [NCH*IN_W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*IN_W +: IN_W] = IN_W'($urandom);
    return v;
  endfunction

  function automatic logic [RECIP_W-1:0] rand_recip();
    return RECIP_W'($urandom_range(1, (1 << RECIP_W) - 1));
  endfunction

  function automatic logic [NCH*IN_W-1:0] pack3(int y, int cb, int cr);
    logic [NCH*IN_W-1:0] v;
    v[0*IN_W +: IN_W] = y[IN_W-1:0];
    v[1*IN_W +: IN_W] = cb[IN_W-1:0];
    v[2*IN_W +: IN_W] = cr[IN_W-1:0];
    return v;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit    exp_ov, exp_en, exp_ir, acc, obs_eob;
    beat_t nb;
    int    bpos;
    #1;
    exp_ov = (ages.size() > 0) && (ages[0] == 3);
    check("out_valid", out_valid, exp_ov);
    obs_eob = out_eob;
    if (exp_ov) begin
      check("out_data", out_data, sb[0].data);
      check("out_sat", out_sat, sb[0].sat);
      check("out_eob", out_eob, sb[0].eob);
    end
    exp_en = !exp_ov || out_ready;
    exp_ir = m_lum_ok && m_chr_ok && exp_en;
    check("tbl_ok", tbl_ok, m_lum_ok && m_chr_ok);
    check("in_ready", in_ready, exp_ir);
    acc  = in_valid && exp_ir;
    bpos = in_sob ? 0 : mpos;
    if (acc) begin
      nb.eob = (bpos == 63);
      for (int c = 0; c < NCH; c++) begin
        int coef, q;
        bit s;
        coef = int'($signed(in_data[c*IN_W +: IN_W]));
        quantize(coef, (c == 0) ? m_lum[bpos] : m_chr[bpos], q, s);
        nb.data[c*OUT_W +: OUT_W] = q[OUT_W-1:0];
        nb.sat[c] = s;
      end
    end
    @(posedge clk);
    if (reset) begin
      sb.delete();
      ages.delete();
      mpos = 0;
      m_lum_ok = 1'b0;
      m_chr_ok = 1'b0;
    end else begin
      if (exp_ov && out_ready) begin
        if (obs_eob) eob_idx.push_back(out_cnt);
        out_cnt++;
        void'(sb.pop_front());
        void'(ages.pop_front());
      end
      if (exp_en) foreach (ages[i]) ages[i]++;
      if (acc) begin
        sb.push_back(nb);
        ages.push_back(0);
        mpos = (bpos + 1) % 64;
      end
      if (tbl_we && tbl_addr == 6'd63) begin
        if (tbl_sel) m_chr_ok = 1'b1;
        else         m_lum_ok = 1'b1;
      end
    end
    if (tbl_we) begin
      if (tbl_sel) m_chr[tbl_addr] = int'(tbl_data);
      else         m_lum[tbl_addr] = int'(tbl_data);
    end
    @(negedge clk);
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    tbl_we = 1'b1; tbl_sel = sel; tbl_addr = addr[5:0]; tbl_data = data[RECIP_W-1:0];
    cycle();
    tbl_we = 1'b0;
  endtask

  task automatic send(input bit sob, input logic [NCH*IN_W-1:0] d);
    in_valid = 1'b1; in_sob = sob; in_data = d;
    cycle();
    in_valid = 1'b0; in_sob = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; in_sob = 1'b0; tbl_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ages.size() == 0) break;
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1; tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = '0; tbl_data = '0;
    in_valid = 1'b0; in_sob = 1'b0; in_data = '0; out_ready = 1'b1;
    mpos = 0; m_lum_ok = 1'b0; m_chr_ok = 1'b0; out_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_eob", out_eob, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_tbl_ok", tbl_ok, 0);

    // streaming before any table load is refused
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = rand_data(); cycle(); end
    in_valid = 1'b0;

    for (int a = 0; a < 64; a++) wr(1'b0, a, int'(rand_recip()));
    for (int a = 0; a < 64; a++) wr(1'b1, a, int'(rand_recip()));
    #1;
    check("tbl_ok_after_load", tbl_ok, 1);
    cycle();

    // directed rounding and saturation points
    wr(1'b0, 0, 4096);
    send(1'b1, pack3(1000, 0, 0));
    repeat (3) cycle();
    #1; check_field("y_pos_1000", 0, 31);
    drain();
    send(1'b1, pack3(-1000, 0, 0));
    repeat (3) cycle();
    #1; check_field("y_neg_1000", 0, -31);
    drain();
    wr(1'b0, 0, 8191);
    send(1'b1, pack3(8191, 0, 0));
    repeat (3) cycle();
    #1; check_field("y_sat_val", 0, 511);
    check("y_sat_flag", out_sat[0], 1);
    drain();
    wr(1'b1, 0, 3855);
    send(1'b1, pack3(0, -8192, 0));
    repeat (3) cycle();
    #1; check_field("cb_neg_val", 1, -241);
    check("cb_sat_flag", out_sat[1], 0);
    drain();

    // 130 back-to-back beats, sob on beats 0 and 64
    out_cnt = 0; eob_idx.delete();
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1; in_sob = (i == 0 || i == 64); in_data = rand_data();
      cycle();
    end
    drain();
    check("eobA_count", eob_idx.size(), 2);
    check("eobA_first", (eob_idx.size() > 0) ? eob_idx[0] : -1, 63);
    check("eobA_second", (eob_idx.size() > 1) ? eob_idx[1] : -1, 127);

    // sob on beat 100 restarts the block count
    out_cnt = 0; eob_idx.delete();
    for (int i = 0; i < 170; i++) begin
      in_valid = 1'b1; in_sob = (i == 0 || i == 100); in_data = rand_data();
      cycle();
    end
    drain();
    check("eobB_count", eob_idx.size(), 2);
    check("eobB_first", (eob_idx.size() > 0) ? eob_idx[0] : -1, 63);
    check("eobB_second", (eob_idx.size() > 1) ? eob_idx[1] : -1, 163);

    // random backpressure with a 5-cycle hold and live table writes
    for (int i = 0; i < 150; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sob    = ($urandom_range(0, 15) == 0);
      in_data   = rand_data();
      out_ready = (i >= 60 && i < 65) ? 1'b0 : ($urandom_range(0, 2) != 0);
      tbl_we    = ($urandom_range(0, 7) == 0);
      tbl_sel   = 1'($urandom_range(0, 1));
      tbl_addr  = 6'($urandom_range(0, 63));
      tbl_data  = rand_recip();
      cycle();
    end
    drain();

    // reset with three beats in flight
    in_valid = 1'b1; in_sob = 1'b1; in_data = rand_data(); cycle();
    in_sob = 1'b0;
    in_data = rand_data(); cycle();
    in_data = rand_data(); cycle();
    in_valid = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    #1;
    check("inflight_rst_out_valid", out_valid, 0);
    check("inflight_rst_tbl_ok", tbl_ok, 0);
    check("inflight_rst_in_ready", in_ready, 0);
    cycle();
    wr(1'b0, 63, int'(rand_recip()));
    wr(1'b1, 63, int'(rand_recip()));
    out_cnt = 0; eob_idx.delete();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_sob = 1'b0; in_data = rand_data();
      cycle();
    end
    drain();
    check("post_rst_eob_count", eob_idx.size(), 1);
    check("post_rst_eob_idx", (eob_idx.size() > 0) ? eob_idx[0] : -1, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
